// File: rtl/button_digit_counter_pkg.sv
// Shared constants and step arithmetic for the push-button digit counter.
// Definitions only: no latency, no flow control.
package button_digit_counter_pkg;

    localparam int VALUE_W                = 4;
    localparam int CLKS_PER_MS            = 25000;
    localparam int DEBOUNCE_MS            = 10;
    localparam int DEFAULT_DEBOUNCE_LIMIT = CLKS_PER_MS * DEBOUNCE_MS;

    typedef logic [VALUE_W-1:0] value_t;

    typedef struct packed {
        value_t value;
        logic   wrap;
    } step_t;

    // Opposing requests in the same cycle cancel out.
    function automatic step_t next_step(
        input value_t value,
        input logic   up,
        input logic   down,
        input value_t max_value
    );
        step_t res;
        res.value = value;
        res.wrap  = 1'b0;
        if (up && !down) begin
            if (value == max_value) begin
                res.value = '0;
                res.wrap  = 1'b1;
            end else begin
                res.value = value + 1'b1;
            end
        end else if (down && !up) begin
            if (value == '0) begin
                res.value = max_value;
                res.wrap  = 1'b1;
            end else begin
                res.value = value - 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/button_digit_counter_debounce.sv
// debounce_filter: 2-flop synchroniser, debounce counter, clean level and one-cycle press pulse.
// Latency: o_press rises DEBOUNCE_LIMIT+2 edges after a stable input is first sampled; no backpressure.
module debounce_filter
    import button_digit_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_meta;
    logic             sync_level;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync_meta  <= i_switch;
            sync_level <= sync_meta;
            press      <= 1'b0;
            // Any cycle back at the debounced level restarts the count.
            if (sync_level != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_level;
                    cnt   <= '0;
                    press <= sync_level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign o_level = level;
    assign o_press = press;

endmodule

// File: rtl/button_digit_counter.sv
// Debounced up/down buttons driving a registered 0..MAX_VALUE digit; optional BUTTON_DIGIT_COUNTER_AUTO_REPEAT_EN.
// Latency: o_value moves DEBOUNCE_LIMIT+3 edges after a stable press is first sampled; no backpressure.
module button_digit_counter
    import button_digit_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int MAX_VALUE      = 15,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_switch_up,
    input  logic               i_switch_down,
    output logic [VALUE_W-1:0] o_value,
    output logic               o_wrap
);

    localparam value_t MAX_V = value_t'(MAX_VALUE);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] step_req;
    step_t      nxt;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_up_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_switch(i_switch_up),
        .o_level (level[0]),
        .o_press (press[0])
    );

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_down_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_switch(i_switch_down),
        .o_level (level[1]),
        .o_press (press[1])
    );

`ifdef BUTTON_DIGIT_COUNTER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [1:0] rpt;

    for (genvar g = 0; g < 2; g++) begin : g_repeat
        logic [RPT_W-1:0] hold_cnt;
        logic             periodic;
        logic             pulse;
        logic             fire;

        // The count starts on the edge after the level rises, so the first
        // repeat lands REPEAT_DELAY cycles after the press step.
        assign fire = periodic ? (hold_cnt == RPT_W'(REPEAT_PERIOD - 1))
                               : (hold_cnt == RPT_W'(REPEAT_DELAY - 1));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                hold_cnt <= '0;
                periodic <= 1'b0;
                pulse    <= 1'b0;
            end else if (!level[g]) begin
                hold_cnt <= '0;
                periodic <= 1'b0;
                pulse    <= 1'b0;
            end else if (fire) begin
                hold_cnt <= '0;
                periodic <= 1'b1;
                pulse    <= !level[1-g];
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
                pulse    <= 1'b0;
            end
        end

        assign rpt[g] = pulse;
    end

    assign step_req = press | rpt;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
    assign step_req          = press;
`endif

    always_comb begin
        nxt = next_step(o_value, step_req[0], step_req[1], MAX_V);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_value <= '0;
            o_wrap  <= 1'b0;
        end else begin
            o_value <= nxt.value;
            o_wrap  <= nxt.wrap;
        end
    end

endmodule

// File: tb/tb_button_digit_counter.sv
// Randomised bench for button_digit_counter: reference model feeds a scoreboard of expected output changes.
// A separate monitor pops and compares each observed change (value, wrap, cycle).
module tb_button_digit_counter;

    localparam int DL  = 4;
    localparam int MAX = 9;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_switch_up;
    logic       i_switch_down;
    logic [3:0] o_value;
    logic       o_wrap;

    typedef struct {
        int cyc;
        int value;
        int wrap;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  m_val = 0;

    button_digit_counter #(
        .DEBOUNCE_LIMIT(DL),
        .MAX_VALUE     (MAX),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_switch_up  (i_switch_up),
        .i_switch_down(i_switch_down),
        .o_value      (o_value),
        .o_wrap       (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic press(input int b);
        if (b == 0) i_switch_up = 1'b1;
        else        i_switch_down = 1'b1;
        wait_cyc($urandom_range(6, 12));
        i_switch_up   = 1'b0;
        i_switch_down = 1'b0;
        wait_cyc($urandom_range(8, 12));
    endtask

    // Reference model: a button's clean level flips after DL consecutive raw
    // samples disagree with it; a rising flip on sample k steps the digit at
    // edge k+3. Repeats are timed from that press step.
    initial begin : model
        bit       lvl[2];
        int       run[2];
        bit [4:0] hist[2];
        int       press_t[2];
        bit [1:0] raw;
        bit [1:0] req;
        int       d;
        int       w;
        for (int b = 0; b < 2; b++) begin
            lvl[b] = 0; run[b] = 0; hist[b] = '0; press_t[b] = 0;
        end
        forever begin
            @(posedge i_clk);
            cyc++;
            if (!i_rst_n) begin
                m_val = 0;
                for (int b = 0; b < 2; b++) begin
                    lvl[b] = 0; run[b] = 0; hist[b] = '0; press_t[b] = 0;
                end
            end else begin
                raw = {i_switch_down, i_switch_up};
                for (int b = 0; b < 2; b++) begin
                    hist[b] = hist[b] << 1;
                    if (raw[b] != lvl[b]) begin
                        run[b]++;
                        if (run[b] == DL) begin
                            lvl[b] = raw[b];
                            run[b] = 0;
                        end
                    end else begin
                        run[b] = 0;
                    end
                    hist[b][0] = lvl[b];
                end
                req = '0;
                for (int b = 0; b < 2; b++) begin
                    if (hist[b][3] && !hist[b][4]) begin
                        req[b]     = 1'b1;
                        press_t[b] = cyc;
                    end
`ifdef BUTTON_DIGIT_COUNTER_AUTO_REPEAT_EN
                    else if (hist[b][4] && !hist[1-b][4]) begin
                        d = cyc - press_t[b];
                        if (d == RD || (d > RD && (d - RD) % RP == 0)) req[b] = 1'b1;
                    end
`endif
                end
                w = 0;
                if (req == 2'b01) begin
                    if (m_val == MAX) begin m_val = 0; w = 1; end
                    else m_val = m_val + 1;
                    exp_q.push_back('{cyc, m_val, w});
                end else if (req == 2'b10) begin
                    if (m_val == 0) begin m_val = MAX; w = 1; end
                    else m_val = m_val - 1;
                    exp_q.push_back('{cyc, m_val, w});
                end
            end
        end
    end

    initial begin : monitor
        int  prev;
        ev_t e;
        prev = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                check("reset_value", int'(o_value), 0);
                check("reset_wrap", int'(o_wrap), 0);
                prev = 0;
            end else if (int'(o_value) != prev || o_wrap) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: value=%0d wrap=%0d at cycle %0d, no change expected",
                             o_value, o_wrap, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("step_value", int'(o_value), e.value);
                    check("step_wrap", int'(o_wrap), e.wrap);
                    check("step_cycle", cyc, e.cyc);
                end
                prev = int'(o_value);
            end
        end
    end

    initial begin : stimulus
        i_rst_n       = 1'b0;
        i_switch_up   = 1'b0;
        i_switch_down = 1'b0;

        // Buttons toggling under reset must have no effect.
        repeat (8) begin
            wait_cyc(1);
            i_switch_up   = 1'($urandom_range(0, 1));
            i_switch_down = 1'($urandom_range(0, 1));
        end
        i_switch_up   = 1'b0;
        i_switch_down = 1'b0;
        wait_cyc(2);
        i_rst_n = 1'b1;
        wait_cyc(12);

        // Single long press: exactly one step.
        i_switch_up = 1'b1;
        wait_cyc(20);
        i_switch_up = 1'b0;
        wait_cyc(12);

        // Pulses shorter than the debounce window.
        repeat (10) begin
            i_switch_up = 1'b1;
            wait_cyc(3);
            i_switch_up = 1'b0;
            wait_cyc(3);
        end
        repeat (10) begin
            if ($urandom_range(0, 1) == 0) i_switch_up = 1'b1;
            else                           i_switch_down = 1'b1;
            wait_cyc($urandom_range(1, DL - 1));
            i_switch_up   = 1'b0;
            i_switch_down = 1'b0;
            wait_cyc($urandom_range(1, 4));
        end
        wait_cyc(10);

        // Climb to MAX, wrap up to 0, then wrap down to MAX and step down once.
        for (int i = 0; i < 12 && m_val != MAX; i++) press(0);
        press(0);
        press(1);
        press(1);

        // Both buttons together cancel.
        i_switch_up   = 1'b1;
        i_switch_down = 1'b1;
        wait_cyc(20);
        i_switch_up   = 1'b0;
        i_switch_down = 1'b0;
        wait_cyc(12);

        // Reset in the middle of an up debounce, released with the button low.
        i_switch_up = 1'b1;
        wait_cyc(2);
        @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        wait_cyc(3);
        i_switch_up = 1'b0;
        i_rst_n     = 1'b1;
        wait_cyc(12);

        // Reset with the button held through release: a fresh press afterwards.
        i_switch_up = 1'b1;
        wait_cyc(3);
        @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        wait_cyc(3);
        i_rst_n = 1'b1;
        wait_cyc(15);
        i_switch_up = 1'b0;
        wait_cyc(12);

`ifdef BUTTON_DIGIT_COUNTER_AUTO_REPEAT_EN
        i_switch_up = 1'b1;
        wait_cyc(DL + 3 + 40);
        i_switch_up = 1'b0;
        wait_cyc(20);
`endif

        // Random button activity.
        repeat (60) begin
            i_switch_up   = 1'($urandom_range(0, 1));
            i_switch_down = 1'($urandom_range(0, 1));
            wait_cyc($urandom_range(1, 14));
        end
        i_switch_up   = 1'b0;
        i_switch_down = 1'b0;
        wait_cyc(20);

        check("pending_expected_steps", exp_q.size(), 0);
        check("final_value", int'(o_value), m_val);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
